// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: command-driven IDLE/RUN/PAUSE wrap-around tick counter with a lap FIFO.
// Ports: clk, resetn (sync, active-low); cmd_valid/cmd_ready/cmd_op command channel
// (00 START, 01 STOP, 10 LAP, 11 CLEAR); count, running, wrap_pulse status;
// lap_valid/lap_ready/lap_data FIFO head handshake; lap_level occupancy; lap_overflow sticky drop flag.
module stopwatch_lap_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  output logic [DATA_WIDTH-1:0]          count,
  output logic                           running,
  output logic                           wrap_pulse,
  output logic                           lap_valid,
  input  logic                           lap_ready,
  output logic [DATA_WIDTH-1:0]          lap_data,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_level,
  output logic                           lap_overflow
);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int LW = $clog2(LAP_DEPTH+1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [DATA_WIDTH-1:0] mem_q [LAP_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  acc, clr, push, pop, full, push_ok, adv;
  assign cmd_ready = resetn;
  assign acc       = cmd_valid && cmd_ready;
  assign clr       = acc && cmd_op == 2'b11;
  assign push      = acc && cmd_op == 2'b10;
  assign pop       = lap_valid && lap_ready;
  assign full      = level_q == LW'(LAP_DEPTH);
  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign push_ok   = push && (!full || pop);
  always_comb begin
    state_d = state_q;
    if (acc) begin
      state_d = cmd_op == 2'b11 ? IDLE :
                cmd_op == 2'b00 ? RUN :
                (cmd_op == 2'b01 && state_q == RUN) ? PAUSE : state_q;
    end
    adv     = state_d == RUN && !clr;
    count_d = clr ? '0 : !adv ? count_q : count_q == DATA_WIDTH'(MAX) ? '0 : count_q + DATA_WIDTH'(1);
    wrap_d  = adv && count_q == DATA_WIDTH'(MAX);
    wr_d    = clr ? '0 : push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = clr ? '0 : pop ? rd_q + AW'(1) : rd_q;
    level_d = clr ? '0 : level_q + LW'(push_ok) - LW'(pop);
    ovf_d   = clr ? 1'b0 : ovf_q || (push && !push_ok);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end
  // Storage needs no reset; pointers and level decide what is visible.
  always_ff @(posedge clk) begin
    if (resetn && push_ok && !clr) mem_q[wr_q] <= count_q;
  end
  assign count        = count_q;
  assign running      = state_q == RUN;
  assign wrap_pulse   = wrap_q;
  assign lap_valid    = level_q != '0;
  assign lap_data     = mem_q[rd_q];
  assign lap_level    = level_q;
  assign lap_overflow = ovf_q;
endmodule
